// File: rtl/sw_input_conditioner_pkg.sv
// Shared definitions for the slide-switch conditioning path.
//   N_SW_DEFAULT : default number of switch bits
//   SW_ADDR      : MMIO address at which software reads the debounced switches (zero-extended)
//   LED_ADDR     : MMIO address of the neighbouring LED register
//   db_state_t   : per-bit debounce FSM state
package sw_input_conditioner_pkg;

    localparam int          N_SW_DEFAULT = 10;
    localparam logic [31:0] SW_ADDR      = 32'hC000_0000;
    localparam logic [31:0] LED_ADDR     = 32'hC000_0004;

    typedef enum logic {
        DB_IDLE  = 1'b0,
        DB_CHECK = 1'b1
    } db_state_t;

endpackage

// File: rtl/sw_input_conditioner_debounce_bit.sv
// Single-bit switch conditioner: synchroniser, debounce FSM with counter,
// edge/rise pulses and a sticky change flag.
// Ports:
//   clk         : system clock, rising edge
//   reset       : asynchronous, active-low reset
//   i_raw       : raw asynchronous switch pin
//   i_event_clr : clears o_event (1 = clear); a coincident set wins
//   o_stable    : debounced level
//   o_edge      : one-cycle pulse when a new level is accepted
//   o_rise      : one-cycle pulse when a 0->1 change is accepted
//   o_event     : sticky flag set by o_edge
module sw_debounce_bit
    import sw_input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    input  logic i_event_clr,
    output logic o_stable,
    output logic o_edge,
    output logic o_rise,
    output logic o_event
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    db_state_t              r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   r_edge;
    logic                   r_rise;
    logic                   r_event;

    // Oldest stage is the only view of the pin that the FSM ever sees.
    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // The counter never passes CNT_MAX: reaching it with a still-mismatching
    // input accepts the new level and returns to idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= DB_IDLE;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_edge   <= 1'b0;
            r_rise   <= 1'b0;
            r_event  <= 1'b0;
        end else begin
            r_edge  <= 1'b0;
            r_rise  <= 1'b0;
            // Uses the registered edge pulse, so a clear in the pulse cycle loses.
            r_event <= r_edge | (r_event & ~i_event_clr);
            case (r_state)
                DB_IDLE: begin
                    if (w_s != r_stable) begin
                        r_state <= DB_CHECK;
                        r_cnt   <= CNT_ONE;
                    end
                end
                DB_CHECK: begin
                    if (w_s == r_stable) begin
                        // Any glitch back to the stable level restarts from scratch.
                        r_state <= DB_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state  <= DB_IDLE;
                        r_cnt    <= '0;
                        r_stable <= w_s;
                        r_edge   <= 1'b1;
                        r_rise   <= w_s;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign o_stable = r_stable;
    assign o_edge   = r_edge;
    assign o_rise   = r_rise;
    assign o_event  = r_event;

endmodule

// File: rtl/sw_input_conditioner.sv
// Board slide-switch conditioner feeding the memory/IO switches port.
// Each bit is synchronised, debounced independently and given edge pulses
// plus a sticky change flag.
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-low reset
//   sw_raw    : raw asynchronous switch pins
//   event_clr : per-bit clear of sw_event (1 = clear)
//   sw_stable : debounced switch levels
//   sw_edge   : one-cycle pulse on any accepted level change
//   sw_rise   : one-cycle pulse on an accepted 0->1 change
//   sw_event  : sticky flag set by sw_edge, cleared by event_clr
module sw_input_conditioner
    import sw_input_conditioner_pkg::*;
#(
    parameter int N_SW            = N_SW_DEFAULT,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] sw_raw,
    input  logic [N_SW-1:0] event_clr,
    output logic [N_SW-1:0] sw_stable,
    output logic [N_SW-1:0] sw_edge,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_event
);

    for (genvar g = 0; g < N_SW; g++) begin : g_bit
        sw_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk         (clk),
            .reset       (reset),
            .i_raw       (sw_raw[g]),
            .i_event_clr (event_clr[g]),
            .o_stable    (sw_stable[g]),
            .o_edge      (sw_edge[g]),
            .o_rise      (sw_rise[g]),
            .o_event     (sw_event[g])
        );
    end

endmodule

// File: tb/tb_sw_input_conditioner.sv
module tb_sw_input_conditioner;

    localparam int N  = 10;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int LAT = SS + DB + 1;   // edges from a clean step to acceptance

    logic         clk;
    logic         reset;
    logic [N-1:0] sw_raw;
    logic [N-1:0] event_clr;
    logic [N-1:0] sw_stable;
    logic [N-1:0] sw_edge;
    logic [N-1:0] sw_rise;
    logic [N-1:0] sw_event;

    int total = 0;
    int bad   = 0;

    // Expected acceptance events, packed as {stable, edge, rise}.
    logic [3*N-1:0] exp_q[$];

    sw_input_conditioner #(
        .N_SW            (N),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .event_clr (event_clr),
        .sw_stable (sw_stable),
        .sw_edge   (sw_edge),
        .sw_rise   (sw_rise),
        .sw_event  (sw_event)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [3*N-1:0] exp_v;
        if (sw_edge !== '0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_edge: got edge=%h rise=%h stable=%h, required no edge",
                         sw_edge, sw_rise, sw_stable);
            end else begin
                exp_v = exp_q.pop_front();
                if ({sw_stable, sw_edge, sw_rise} !== exp_v) begin
                    bad++;
                    $display("FAIL edge_event: got stable=%h edge=%h rise=%h, required stable=%h edge=%h rise=%h",
                             sw_stable, sw_edge, sw_rise, exp_v[3*N-1:2*N], exp_v[2*N-1:N], exp_v[N-1:0]);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [N-1:0] st, input logic [N-1:0] ed, input logic [N-1:0] rs);
        exp_q.push_back({st, ed, rs});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b0;
        sw_raw = 10'h3FF;
        event_clr = '0;
        tick(3);
        total++;
        if ({sw_stable, sw_edge, sw_rise, sw_event} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got stable=%h edge=%h rise=%h event=%h, required all 0",
                     sw_stable, sw_edge, sw_rise, sw_event);
        end
        push_exp(10'h3FF, 10'h3FF, 10'h3FF);
        reset = 1'b1;
        for (int k = 1; k < LAT; k++) begin
            tick(1);
            total++;
            if (sw_stable !== '0) begin
                bad++;
                $display("FAIL reset_release_early: edge %0d got stable=%h, required 000", k, sw_stable);
            end
        end
        tick(1);
        total++;
        if (sw_stable !== 10'h3FF || sw_edge !== 10'h3FF || sw_rise !== 10'h3FF) begin
            bad++;
            $display("FAIL reset_release_accept: got stable=%h edge=%h rise=%h, required 3ff 3ff 3ff",
                     sw_stable, sw_edge, sw_rise);
        end
        tick(1);
        total++;
        if (sw_edge !== '0 || sw_event !== 10'h3FF) begin
            bad++;
            $display("FAIL reset_release_after: got edge=%h event=%h, required 000 3ff", sw_edge, sw_event);
        end
    endtask

    task automatic test_fall;
        push_exp(10'h3FE, 10'h001, 10'h000);
        sw_raw = 10'h3FE;
        tick(LAT - 1);
        total++;
        if (sw_stable !== 10'h3FF) begin
            bad++;
            $display("FAIL fall_early: got stable=%h, required 3ff", sw_stable);
        end
        tick(1);
        total++;
        if (sw_stable !== 10'h3FE || sw_edge !== 10'h001 || sw_rise !== 10'h000) begin
            bad++;
            $display("FAIL fall_accept: got stable=%h edge=%h rise=%h, required 3fe 001 000",
                     sw_stable, sw_edge, sw_rise);
        end
        tick(1);
        total++;
        if (sw_edge !== '0) begin
            bad++;
            $display("FAIL fall_pulse_width: got edge=%h, required 000", sw_edge);
        end
    endtask

    task automatic test_event_clr;
        event_clr = 10'h001;
        tick(1);
        event_clr = '0;
        total++;
        if (sw_event !== 10'h3FE) begin
            bad++;
            $display("FAIL event_clr: got event=%h, required 3fe", sw_event);
        end
    endtask

    task automatic test_glitch;
        sw_raw = 10'h3FF;
        tick(3);
        sw_raw = 10'h3FE;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            total++;
            if (sw_stable !== 10'h3FE || sw_edge[0] !== 1'b0 || sw_event[0] !== 1'b0) begin
                bad++;
                $display("FAIL glitch: cycle %0d got stable=%h edge=%h event=%h, required 3fe, bit0 clear",
                         k, sw_stable, sw_edge, sw_event);
            end
        end
    endtask

    task automatic test_set_wins;
        push_exp(10'h3FF, 10'h001, 10'h001);
        sw_raw = 10'h3FF;
        tick(LAT);
        total++;
        if (sw_edge !== 10'h001 || sw_rise !== 10'h001 || sw_stable !== 10'h3FF) begin
            bad++;
            $display("FAIL set_wins_accept: got stable=%h edge=%h rise=%h, required 3ff 001 001",
                     sw_stable, sw_edge, sw_rise);
        end
        event_clr = 10'h001;
        tick(1);
        event_clr = '0;
        total++;
        if (sw_event[0] !== 1'b1) begin
            bad++;
            $display("FAIL set_wins: got event0=%b, required 1", sw_event[0]);
        end
        tick(1);
        total++;
        if (sw_event !== 10'h3FF) begin
            bad++;
            $display("FAIL set_wins_hold: got event=%h, required 3ff", sw_event);
        end
    endtask

    task automatic test_back_to_back;
        // Two bits fall together, then rise one cycle apart.
        push_exp(10'h1FE, 10'h201, 10'h000);
        sw_raw = 10'h1FE;
        tick(LAT);
        total++;
        if (sw_stable !== 10'h1FE || sw_edge !== 10'h201) begin
            bad++;
            $display("FAIL simultaneous_fall: got stable=%h edge=%h, required 1fe 201", sw_stable, sw_edge);
        end
        tick(2);
        push_exp(10'h3FE, 10'h200, 10'h200);
        push_exp(10'h3FF, 10'h001, 10'h001);
        sw_raw = 10'h3FE;
        tick(1);
        sw_raw = 10'h3FF;
        tick(LAT - 1);
        total++;
        if (sw_stable !== 10'h3FE || sw_edge !== 10'h200 || sw_rise !== 10'h200) begin
            bad++;
            $display("FAIL stagger_bit9: got stable=%h edge=%h rise=%h, required 3fe 200 200",
                     sw_stable, sw_edge, sw_rise);
        end
        tick(1);
        total++;
        if (sw_stable !== 10'h3FF || sw_edge !== 10'h001 || sw_rise !== 10'h001) begin
            bad++;
            $display("FAIL stagger_bit0: got stable=%h edge=%h rise=%h, required 3ff 001 001",
                     sw_stable, sw_edge, sw_rise);
        end
    endtask

    task automatic test_reset_mid_count;
        sw_raw = 10'h3FE;
        tick(5);                 // bit0 counter now at 3
        reset = 1'b0;
        #2;
        total++;
        if ({sw_stable, sw_edge, sw_rise, sw_event} !== '0) begin
            bad++;
            $display("FAIL async_reset: got stable=%h edge=%h rise=%h event=%h, required all 0",
                     sw_stable, sw_edge, sw_rise, sw_event);
        end
        tick(2);
        push_exp(10'h3FE, 10'h3FE, 10'h3FE);
        reset = 1'b1;
        for (int k = 1; k < LAT; k++) begin
            tick(1);
            total++;
            if (sw_stable !== '0) begin
                bad++;
                $display("FAIL midcount_early: edge %0d got stable=%h, required 000", k, sw_stable);
            end
        end
        tick(1);
        total++;
        if (sw_stable !== 10'h3FE || sw_edge !== 10'h3FE || sw_rise !== 10'h3FE) begin
            bad++;
            $display("FAIL midcount_accept: got stable=%h edge=%h rise=%h, required 3fe 3fe 3fe",
                     sw_stable, sw_edge, sw_rise);
        end
    endtask

    task automatic test_random_hold;
        logic [N-1:0] v;
        v = N'($urandom_range(0, 1023));
        push_exp(v, v ^ 10'h3FE, v & ~10'h3FE);
        if (v == 10'h3FE) exp_q.delete(exp_q.size() - 1);
        sw_raw = v;
        tick(LAT + 2);
        total++;
        if (sw_stable !== v) begin
            bad++;
            $display("FAIL random_level: got stable=%h, required %h", sw_stable, v);
        end
    endtask

    initial begin
        reset = 1'b0;
        sw_raw = '0;
        event_clr = '0;
        test_reset;
        test_fall;
        test_event_clr;
        test_glitch;
        test_set_wins;
        test_back_to_back;
        test_reset_mid_count;
        test_random_hold;
        tick(3);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_edges: got %0d pending expected events, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
